fetch_unit: RTL

- Fetch stage directly upstream of the decode-side fetch buffer.
- Generates sequential PCs and issues reads to a synchronous instruction memory with 1-cycle read latency.
- Holds returned instructions, each paired with its PC, in a small FIFO queue.
- Presents queue entries to the fetch buffer through a valid/ready handshake, and supports a redirect that flushes all wrong-path state.

---
 rtl/fetch_unit.sv | 115 +++++++++++
 1 files changed

// File: rtl/fetch_unit.sv
// Fetch stage: sequential PC generation, 1-cycle synchronous imem reads, and a small
// {pc, instr} FIFO presented downstream over valid/ready, with redirect flush.
module fetch_unit #(
    parameter int unsigned           ADDR_WIDTH  = 12,
    parameter int unsigned           INSTR_WIDTH = 32,
    parameter int unsigned           DEPTH       = 4,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC    = '0
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   redirect_valid,
    input  logic [ADDR_WIDTH-1:0]  redirect_pc,
    output logic                   imem_req_valid,
    output logic [ADDR_WIDTH-1:0]  imem_addr,
    input  logic [INSTR_WIDTH-1:0] imem_rdata,
    output logic                   out_valid,
    output logic [ADDR_WIDTH-1:0]  out_pc,
    output logic [INSTR_WIDTH-1:0] out_instr,
    input  logic                   out_ready
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [CNT_W:0]        DEPTH_C = DEPTH[CNT_W:0];
    localparam logic [ADDR_WIDTH-1:0] PC_STEP = ADDR_WIDTH'(4);
    localparam logic [PTR_W-1:0]      PTR_ONE = PTR_W'(1);
    localparam logic [CNT_W-1:0]      CNT_ONE = CNT_W'(1);

    logic [ADDR_WIDTH-1:0]  pc_q, pc_d;
    logic [ADDR_WIDTH-1:0]  inflight_pc_q;
    logic                   inflight_q;
    logic [CNT_W-1:0]       count_q, count_d;
    logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH-1:0]  pc_mem    [DEPTH];
    logic [INSTR_WIDTH-1:0] instr_mem [DEPTH];

    logic           issue;
    logic           enq;
    logic           deq;
    logic [CNT_W:0] occupancy;
    logic           unused_redirect_lsb;

    assign unused_redirect_lsb = ^redirect_pc[1:0];

    // In-flight read holds a credit, so the queue can never overflow.
    assign occupancy = {1'b0, count_q} + {{CNT_W{1'b0}}, inflight_q};
    assign issue     = rst_n && !redirect_valid && (occupancy < DEPTH_C);
    assign enq       = inflight_q && !redirect_valid;

    assign imem_req_valid = issue;
    assign imem_addr      = pc_q;

    assign out_valid = (count_q != '0) && !redirect_valid;
    assign deq       = out_valid && out_ready;
    assign out_pc    = rst_n ? pc_mem[rd_ptr_q]    : '0;
    assign out_instr = rst_n ? instr_mem[rd_ptr_q] : '0;

    always_comb begin
        pc_d     = pc_q;
        count_d  = count_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        if (redirect_valid) begin
            pc_d     = {redirect_pc[ADDR_WIDTH-1:2], 2'b00};
            count_d  = '0;
            rd_ptr_d = '0;
            wr_ptr_d = '0;
        end else begin
            if (issue) begin
                pc_d = pc_q + PC_STEP;
            end
            if (enq) begin
                wr_ptr_d = wr_ptr_q + PTR_ONE;
            end
            if (deq) begin
                rd_ptr_d = rd_ptr_q + PTR_ONE;
            end
            unique case ({enq, deq})
                2'b10:   count_d = count_q + CNT_ONE;
                2'b01:   count_d = count_q - CNT_ONE;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q          <= RESET_PC;
            inflight_q    <= 1'b0;
            inflight_pc_q <= '0;
            count_q       <= '0;
            rd_ptr_q      <= '0;
            wr_ptr_q      <= '0;
        end else begin
            pc_q       <= pc_d;
            inflight_q <= issue;
            count_q    <= count_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            if (issue) begin
                inflight_pc_q <= pc_q;
            end
        end
    end

    // Storage needs no reset: entries are only visible through count_q.
    always_ff @(posedge clk) begin
        if (enq) begin
            pc_mem[wr_ptr_q]    <= inflight_pc_q;
            instr_mem[wr_ptr_q] <= imem_rdata;
        end
    end

endmodule
